lut_bist_ctrl: RTL
==================

LUT_BIST_CTRL -- requirements
Module: lut_bist_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 2, meaning wait cycles between driving x_o and sampling y_i (range 0..15).
REQ-002 SHALL have parameter EXP_MAP, default lut_bist_pkg::LUT1596_EXP_MAP, meaning the 16-bit expected truth table (bit i = expected y for x = i).
REQ-003 SHALL have port clk  in  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  in  1  one-cycle request to begin a sweep.
REQ-006 SHALL have port abort  in  1  cancels a running sweep.
REQ-007 SHALL have port x_o  out  4  code driven to the LUT input x.
REQ-008 SHALL have port y_i  in  1  LUT output y.
REQ-009 SHALL have port busy  out  1  high while a sweep is in progress.
REQ-010 SHALL have port done  out  1  one-cycle pulse on sweep completion.
REQ-011 SHALL have port pass  out  1  result of the last completed sweep.
REQ-012 SHALL have port cnt_one  out  5  count of codes where y was expected 1 but read 0.
REQ-013 SHALL have port cnt_zero  out  5  count of codes where y was expected 0 but read 1.
REQ-014 SHALL have port fail_map  out  16  per-code mismatch flags (see Configuration).

Function
REQ-015 SHALL implement states IDLE, APPLY, SETTLE, SAMPLE, DONE.
REQ-016 IDLE: start=1 SHALL clear cnt_one, cnt_zero, fail_map and pass, set idx=0, and go to APPLY.
REQ-017 APPLY SHALL drive x_o=idx for one cycle, then go to SETTLE, or to SAMPLE directly if SETTLE_CYC=0.
REQ-018 SETTLE SHALL hold x_o for exactly SETTLE_CYC cycles, then go to SAMPLE.
REQ-019 SAMPLE SHALL compare y_i with EXP_MAP[idx]: exp 1/read 0 increments cnt_one; exp 0/read 1 increments cnt_zero.
REQ-020 SAMPLE SHALL go to DONE when idx=15; otherwise it SHALL increment idx and go to APPLY.
REQ-021 Per-code cost SHALL be SETTLE_CYC+2 cycles; done SHALL rise 16*(SETTLE_CYC+2)+1 cycles after the edge that samples start.
REQ-022 DONE SHALL assert done for one cycle, set pass = (cnt_one==0 && cnt_zero==0), then return to IDLE.
REQ-023 busy SHALL be high in APPLY, SETTLE and SAMPLE, and low in IDLE and DONE.
REQ-024 start while busy SHALL be ignored.
REQ-025 abort while busy SHALL return to IDLE next cycle with pass=0, no done pulse, and counters frozen; abort SHALL win over a simultaneous idx=15 SAMPLE.
REQ-026 Counters SHALL be 5 bits and SHALL NOT wrap; the maximum value is 16.
REQ-027 x_o SHALL hold its last value in IDLE.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, x_o=0, busy=0, done=0, pass=0, cnt_one=0, cnt_zero=0, fail_map=0, including mid-sweep.
REQ-029 After rst_n deasserts, the first start SHALL be honoured on the first rising edge at which it is high.

Configuration
REQ-030 With macro LUT_BIST_FAILMAP_EN defined, SAMPLE SHALL set fail_map[idx]=1 on mismatch.
REQ-031 Without LUT_BIST_FAILMAP_EN, fail_map SHALL be constant 0 and no fail_map storage SHALL be synthesised.

Structure
REQ-032 Package lut_bist_pkg SHALL hold the state enum typedef and LUT1596_EXP_MAP = 16'h0222 (codes 1, 5, 9 high).
REQ-033 The settle countdown SHALL be a sub-module lut_bist_timer (load, count, expire).
REQ-034 lut_1596 SHALL be instantiated outside this block and connected via x_o/y_i.

Verification
REQ-035 Correct LUT, SETTLE_CYC=2, start pulse -> done at cycle 65 after start, pass=1, cnt_one=0, cnt_zero=0, fail_map=0.
REQ-036 y_i forced 0 -> pass=0, cnt_one=3, cnt_zero=0, fail_map=16'h0222 (macro on) or 0 (macro off).
REQ-037 y_i forced 1 -> cnt_one=0, cnt_zero=13, pass=0.
REQ-038 abort during idx=7 -> busy low next cycle, no done pulse, pass=0; a new start then completes normally with pass=1.
REQ-039 rst_n low during SETTLE at idx=4 -> all outputs at reset values asynchronously; start re-pulsed while busy is ignored (done at cycle 65 of the first start).
REQ-040 SETTLE_CYC=0 -> x_o steps 0..15 every 2 cycles, done at cycle 33.

Source files
------------

// File: rtl/lut_bist_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lut_bist_pkg
// Description : Shared types and constants for the LUT built-in self-test.
// Revision    : 1.0 - initial release
// ============================================================================
package lut_bist_pkg;

    // Golden truth table of lut_1596: y is high for x = 1, 5 and 9.
    localparam logic [15:0] LUT1596_EXP_MAP = 16'h0222;

    localparam logic [4:0] c_cnt_max = 5'd16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } bist_state_t;

    function automatic logic [4:0] sat_inc(input logic [4:0] v);
        return (v >= c_cnt_max) ? v : v + 5'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lut_bist_timer.sv
`default_nettype none
// ============================================================================
// Module      : lut_bist_timer
// Description : Loadable down-counter; expire flags the last settle cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module lut_bist_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             count,
    input  logic [WIDTH-1:0] load_val,
    output logic             expire
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (count && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Expire while the final cycle is in progress so the FSM leaves on time.
    assign expire = (r_cnt <= WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/lut_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lut_bist_ctrl
// Description : Sweeps all 16 LUT input codes and compares y against EXP_MAP.
//               Define LUT_BIST_FAILMAP_EN to keep per-code mismatch flags.
// Revision    : 1.0 - initial release
// ============================================================================
module lut_bist_ctrl
    import lut_bist_pkg::*;
#(
    parameter int          SETTLE_CYC = 2,
    parameter logic [15:0] EXP_MAP    = lut_bist_pkg::LUT1596_EXP_MAP
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    output logic [3:0]  x_o,
    input  logic        y_i,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [4:0]  cnt_one,
    output logic [4:0]  cnt_zero,
    output logic [15:0] fail_map
);

    localparam logic [3:0] c_settle      = 4'(SETTLE_CYC);
    localparam logic       c_skip_settle = (SETTLE_CYC == 0);

    bist_state_t r_state;
    bist_state_t w_next;

    logic [3:0] r_idx;
    logic [4:0] r_cnt_one;
    logic [4:0] r_cnt_zero;
    logic       r_pass;
    logic       r_done;

    logic w_busy;
    logic w_sweep_start;
    logic w_abort;
    logic w_sample;
    logic w_y_exp;
    logic w_tmr_load;
    logic w_tmr_count;
    logic w_tmr_expire;

    assign w_busy        = (r_state == ST_APPLY) || (r_state == ST_SETTLE) ||
                           (r_state == ST_SAMPLE);
    assign w_sweep_start = (r_state == ST_IDLE) && start;
    assign w_abort       = w_busy && abort;
    assign w_sample      = (r_state == ST_SAMPLE) && !abort;
    assign w_y_exp       = EXP_MAP[r_idx];

    lut_bist_timer #(
        .WIDTH (4)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_tmr_load),
        .count    (w_tmr_count),
        .load_val (c_settle),
        .expire   (w_tmr_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_tmr_load  = 1'b0;
        w_tmr_count = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next = ST_APPLY;
            end
            ST_APPLY: begin
                w_tmr_load = 1'b1;
                w_next     = c_skip_settle ? ST_SAMPLE : ST_SETTLE;
            end
            ST_SETTLE: begin
                w_tmr_count = 1'b1;
                if (w_tmr_expire) w_next = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                w_next = (r_idx == 4'd15) ? ST_DONE : ST_APPLY;
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
        // Abort outranks every in-sweep transition, including the final sample.
        if (w_abort) w_next = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_cnt_one  <= '0;
            r_cnt_zero <= '0;
            r_pass     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= (r_state == ST_DONE);
            if (w_sweep_start) begin
                r_idx      <= '0;
                r_cnt_one  <= '0;
                r_cnt_zero <= '0;
                r_pass     <= 1'b0;
            end else if (w_abort) begin
                r_pass <= 1'b0;
            end else if (w_sample) begin
                if (w_y_exp && !y_i) r_cnt_one  <= sat_inc(r_cnt_one);
                if (!w_y_exp && y_i) r_cnt_zero <= sat_inc(r_cnt_zero);
                if (r_idx != 4'd15) r_idx <= r_idx + 4'd1;
            end else if (r_state == ST_DONE) begin
                r_pass <= (r_cnt_one == '0) && (r_cnt_zero == '0);
            end
        end
    end

`ifdef LUT_BIST_FAILMAP_EN
    logic [15:0] r_fail_map;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fail_map <= '0;
        end else if (w_sweep_start) begin
            r_fail_map <= '0;
        end else if (w_sample && (w_y_exp != y_i)) begin
            r_fail_map[r_idx] <= 1'b1;
        end
    end

    assign fail_map = r_fail_map;
`else
    assign fail_map = '0;
`endif

    // The code register doubles as the LUT drive, so x_o holds in IDLE.
    assign x_o      = r_idx;
    assign busy     = w_busy;
    assign done     = r_done;
    assign pass     = r_pass;
    assign cnt_one  = r_cnt_one;
    assign cnt_zero = r_cnt_zero;

endmodule
`default_nettype wire
